// File: rtl/rv32imf_pkg.sv
// Shared constants and bus payload types for the rv32imf interrupt source slice.
package rv32imf_pkg;

    localparam int unsigned CSR_MSIX_BIT = 3;
    localparam int unsigned CSR_MTIX_BIT = 7;
    localparam int unsigned CSR_MEIX_BIT = 11;

    localparam int unsigned IRQSRC_ADDR_W    = 8;
    localparam int unsigned IRQSRC_DATA_W    = 32;
    localparam int unsigned IRQSRC_FAST_BASE = 16;
    localparam int unsigned IRQSRC_FAST_NUM  = 16;

    localparam logic [IRQSRC_ADDR_W-1:0] IRQSRC_MSIP_OFF        = 8'h00;
    localparam logic [IRQSRC_ADDR_W-1:0] IRQSRC_MTIMECMP_LO_OFF = 8'h04;
    localparam logic [IRQSRC_ADDR_W-1:0] IRQSRC_MTIMECMP_HI_OFF = 8'h08;
    localparam logic [IRQSRC_ADDR_W-1:0] IRQSRC_MTIME_LO_OFF    = 8'h0C;
    localparam logic [IRQSRC_ADDR_W-1:0] IRQSRC_MTIME_HI_OFF    = 8'h10;
    localparam logic [IRQSRC_ADDR_W-1:0] IRQSRC_PRESCALE_OFF    = 8'h14;
    localparam logic [IRQSRC_ADDR_W-1:0] IRQSRC_FAST_PEND_OFF   = 8'h18;

    localparam logic [63:0] IRQSRC_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // One-cycle bus response payload.
    typedef struct packed {
        logic                     rvalid;
        logic                     err;
        logic [IRQSRC_DATA_W-1:0] rdata;
    } irqsrc_rsp_t;

endpackage

// File: rtl/rv32imf_irq_source_if.sv
// Single-cycle register bus between the core side and the interrupt source.
interface rv32imf_irq_source_if;
    import rv32imf_pkg::*;

    logic                     req_i;
    logic                     we_i;
    logic [IRQSRC_ADDR_W-1:0] addr_i;
    logic [IRQSRC_DATA_W-1:0] wdata_i;
    logic                     gnt_o;
    logic                     rvalid_o;
    logic [IRQSRC_DATA_W-1:0] rdata_o;
    logic                     err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/rv32imf_irq_source_timer.sv
// Machine timer: prescaler, 64-bit mtime, mtimecmp and the registered MTI compare.
module rv32imf_irq_source_timer
    import rv32imf_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           wdata_i,
    input  logic                  ld_cmp_lo_i,
    input  logic                  ld_cmp_hi_i,
    input  logic                  ld_time_lo_i,
    input  logic                  ld_time_hi_i,
    input  logic                  ld_prescale_i,
    output logic [63:0]           mtime_o,
    output logic [63:0]           mtimecmp_o,
    output logic [PRESCALE_W-1:0] prescale_o,
    output logic                  mti_o
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  mti_q, mti_d;
    logic                  tick_c;
    logic                  ld_time_c;

    // A software load of mtime freezes both the increment and the prescaler for that cycle.
    always_comb begin
        tick_c     = (pcnt_q == prescale_q);
        ld_time_c  = ld_time_lo_i | ld_time_hi_i;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;

        if (ld_prescale_i) prescale_d = wdata_i[PRESCALE_W-1:0];
        if (ld_cmp_lo_i)   mtimecmp_d[31:0]  = wdata_i;
        if (ld_cmp_hi_i)   mtimecmp_d[63:32] = wdata_i;

        if (ld_time_c) begin
            if (ld_time_lo_i) mtime_d[31:0]  = wdata_i;
            if (ld_time_hi_i) mtime_d[63:32] = wdata_i;
        end else if (tick_c) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (ld_prescale_i) begin
            pcnt_d = '0;
        end else if (!ld_time_c) begin
            pcnt_d = tick_c ? '0 : pcnt_q + PRESCALE_W'(1);
        end

        mti_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q     <= '0;
            prescale_q <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= IRQSRC_MTIMECMP_RST;
            mti_q      <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            prescale_q <= prescale_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mti_q      <= mti_d;
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = mtimecmp_q;
    assign prescale_o = prescale_q;
    assign mti_o      = mti_q;

endmodule

// File: rtl/rv32imf_irq_source.sv
// Interrupt source: register bus decode, MSIP, fast-interrupt pending bits,
// MEI synchroniser and the irq vector fed to the core's interrupt controller.
module rv32imf_irq_source
    import rv32imf_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    rv32imf_irq_source_if.slave        bus,
    input  logic                       meip_i,
    input  logic [IRQSRC_FAST_NUM-1:0] irq_fast_i,
    output logic [31:0]                irq_o
);

    logic [IRQSRC_ADDR_W-1:0]   word_addr_c;
    logic                       wr_c;
    logic                       hit_c;
    logic [IRQSRC_DATA_W-1:0]   rd_data_c;
    logic                       ld_msip_c, ld_pend_c;
    logic                       ld_cmp_lo_c, ld_cmp_hi_c;
    logic                       ld_time_lo_c, ld_time_hi_c, ld_prescale_c;
    logic                       unused_addr;

    logic [63:0]                mtime;
    logic [63:0]                mtimecmp;
    logic [PRESCALE_W-1:0]      prescale;
    logic                       mti;

    logic                       msip_q, msip_d;
    logic [IRQSRC_FAST_NUM-1:0] fast_prev_q;
    logic [IRQSRC_FAST_NUM-1:0] pend_q, pend_d;
    logic                       mei_s1_q, mei_s_q;
    irqsrc_rsp_t                rsp_q, rsp_d;

    assign unused_addr = ^bus.addr_i[1:0];
    assign bus.gnt_o   = bus.req_i;
    assign word_addr_c = {bus.addr_i[IRQSRC_ADDR_W-1:2], 2'b00};
    assign wr_c        = bus.req_i & bus.we_i;

    rv32imf_irq_source_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .wdata_i       (bus.wdata_i),
        .ld_cmp_lo_i   (ld_cmp_lo_c),
        .ld_cmp_hi_i   (ld_cmp_hi_c),
        .ld_time_lo_i  (ld_time_lo_c),
        .ld_time_hi_i  (ld_time_hi_c),
        .ld_prescale_i (ld_prescale_c),
        .mtime_o       (mtime),
        .mtimecmp_o    (mtimecmp),
        .prescale_o    (prescale),
        .mti_o         (mti)
    );

    // Register decode: read mux and write strobes.
    always_comb begin
        hit_c         = 1'b1;
        rd_data_c     = '0;
        ld_msip_c     = 1'b0;
        ld_pend_c     = 1'b0;
        ld_cmp_lo_c   = 1'b0;
        ld_cmp_hi_c   = 1'b0;
        ld_time_lo_c  = 1'b0;
        ld_time_hi_c  = 1'b0;
        ld_prescale_c = 1'b0;
        case (word_addr_c)
            IRQSRC_MSIP_OFF: begin
                rd_data_c = {31'b0, msip_q};
                ld_msip_c = wr_c;
            end
            IRQSRC_MTIMECMP_LO_OFF: begin
                rd_data_c   = mtimecmp[31:0];
                ld_cmp_lo_c = wr_c;
            end
            IRQSRC_MTIMECMP_HI_OFF: begin
                rd_data_c   = mtimecmp[63:32];
                ld_cmp_hi_c = wr_c;
            end
            IRQSRC_MTIME_LO_OFF: begin
                rd_data_c    = mtime[31:0];
                ld_time_lo_c = wr_c;
            end
            IRQSRC_MTIME_HI_OFF: begin
                rd_data_c    = mtime[63:32];
                ld_time_hi_c = wr_c;
            end
            IRQSRC_PRESCALE_OFF: begin
                rd_data_c     = 32'(prescale);
                ld_prescale_c = wr_c;
            end
            IRQSRC_FAST_PEND_OFF: begin
                rd_data_c = 32'(pend_q);
                ld_pend_c = wr_c;
            end
            default: hit_c = 1'b0;
        endcase
    end

    // A new rising edge outranks a simultaneous W1C on the same bit.
    always_comb begin
        msip_d = ld_msip_c ? bus.wdata_i[0] : msip_q;
        pend_d = (pend_q & ~(ld_pend_c ? bus.wdata_i[IRQSRC_FAST_NUM-1:0] : '0))
               | (irq_fast_i & ~fast_prev_q);
        rsp_d.rvalid = bus.req_i;
        rsp_d.err    = bus.req_i & ~hit_c;
        rsp_d.rdata  = (bus.req_i & ~bus.we_i) ? rd_data_c : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q      <= 1'b0;
            fast_prev_q <= '0;
            pend_q      <= '0;
            mei_s1_q    <= 1'b0;
            mei_s_q     <= 1'b0;
            rsp_q       <= '0;
        end else begin
            msip_q      <= msip_d;
            fast_prev_q <= irq_fast_i;
            pend_q      <= pend_d;
            mei_s1_q    <= meip_i;
            mei_s_q     <= mei_s1_q;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.rvalid_o = rsp_q.rvalid;
    assign bus.rdata_o  = rsp_q.rdata;
    assign bus.err_o    = rsp_q.err;

    // irq vector is a pure wiring of flop outputs.
    always_comb begin
        irq_o                                           = '0;
        irq_o[CSR_MSIX_BIT]                             = msip_q;
        irq_o[CSR_MTIX_BIT]                             = mti;
        irq_o[CSR_MEIX_BIT]                             = mei_s_q;
        irq_o[IRQSRC_FAST_BASE +: IRQSRC_FAST_NUM]      = pend_q;
    end

endmodule

// File: tb/tb_rv32imf_irq_source.sv
// Directed bench for rv32imf_irq_source with hand-computed expected values.
module tb_rv32imf_irq_source;
    import rv32imf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        meip_i;
    logic [15:0] irq_fast_i;
    logic [31:0] irq_o;
    int          n_cmp;
    int          n_err;

    rv32imf_irq_source_if bus_if ();

    rv32imf_irq_source #(
        .PRESCALE_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.slave),
        .meip_i     (meip_i),
        .irq_fast_i (irq_fast_i),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the next one with the response sampled.
    task automatic bus_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        bus_if.req_i   = 1'b1;
        bus_if.we_i    = we;
        bus_if.addr_i  = addr;
        bus_if.wdata_i = wdata;
        #1;
        check_eq("gnt", 64'(bus_if.gnt_o), 64'd1);
        @(posedge clk);
        #1;
        check_eq("rvalid", 64'(bus_if.rvalid_o), 64'd1);
        rdata          = bus_if.rdata_o;
        err            = bus_if.err_o;
        bus_if.req_i   = 1'b0;
        bus_if.we_i    = 1'b0;
        bus_if.addr_i  = '0;
        bus_if.wdata_i = '0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        e;
        bus_xfer(1'b1, addr, wdata, d, e);
        check_eq("wr_err", 64'(e), 64'd0);
        check_eq("wr_rdata", 64'(d), 64'd0);
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        bus_xfer(1'b0, addr, 32'h0, d, e);
        check_eq(tag, 64'(d), 64'(exp));
        check_eq({tag, "_err"}, 64'(e), 64'd0);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          exp_t;

        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        meip_i         = 1'b0;
        irq_fast_i     = '0;
        bus_if.req_i   = 1'b0;
        bus_if.we_i    = 1'b0;
        bus_if.addr_i  = '0;
        bus_if.wdata_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_irq", 64'(irq_o), 64'd0);
        check_eq("rst_rvalid", 64'(bus_if.rvalid_o), 64'd0);
        check_eq("rst_rdata", 64'(bus_if.rdata_o), 64'd0);
        rst_n = 1'b1;

        // Reset values; mtime is read before its first increment.
        rd("rst_mtime_lo", IRQSRC_MTIME_LO_OFF, 32'h0);
        rd("rst_mtime_hi", IRQSRC_MTIME_HI_OFF, 32'h0);
        rd("rst_msip", IRQSRC_MSIP_OFF, 32'h0);
        rd("rst_cmp_lo", IRQSRC_MTIMECMP_LO_OFF, 32'hFFFF_FFFF);
        rd("rst_cmp_hi", IRQSRC_MTIMECMP_HI_OFF, 32'hFFFF_FFFF);
        rd("rst_prescale", IRQSRC_PRESCALE_OFF, 32'h0);
        rd("rst_pend", IRQSRC_FAST_PEND_OFF, 32'h0);
        check_eq("rst_irq_after_reads", 64'(irq_o), 64'd0);
        bus_xfer(1'b0, 8'h40, 32'h0, d, e);
        check_eq("unmapped_rdata", 64'(d), 64'd0);
        check_eq("unmapped_err", 64'(e), 64'd1);
        bus_xfer(1'b1, 8'h1C, 32'hDEAD_BEEF, d, e);
        check_eq("unmapped_wr_err", 64'(e), 64'd1);
        idle();
        check_eq("idle_rvalid", 64'(bus_if.rvalid_o), 64'd0);

        // Prescaler 3: mtime steps every 4 cycles, MTI one cycle after mtime reaches 5.
        wr(IRQSRC_PRESCALE_OFF, 32'd3);
        wr(IRQSRC_MTIME_HI_OFF, 32'd0);
        wr(IRQSRC_MTIME_LO_OFF, 32'd0);
        wr(IRQSRC_MTIMECMP_HI_OFF, 32'd0);
        wr(IRQSRC_MTIMECMP_LO_OFF, 32'd5);
        for (int j = 0; j < 24; j++) begin
            exp_t = (j + 2) / 4;
            bus_xfer(1'b0, IRQSRC_MTIME_LO_OFF, 32'h0, d, e);
            check_eq("ps_mtime_lo", 64'(d), 64'(exp_t));
            check_eq("ps_mti", 64'(irq_o[CSR_MTIX_BIT]), 64'(exp_t >= 5));
        end
        rd("ps_prescale", IRQSRC_PRESCALE_OFF, 32'd3);

        // 32-bit carry into MTIME_HI, and load cycles suppressing the increment.
        wr(IRQSRC_PRESCALE_OFF, 32'd0);
        wr(IRQSRC_MTIME_LO_OFF, 32'hFFFF_FFFF);
        wr(IRQSRC_MTIME_HI_OFF, 32'h0);
        rd("wrap_lo_pre", IRQSRC_MTIME_LO_OFF, 32'hFFFF_FFFF);
        rd("wrap_hi", IRQSRC_MTIME_HI_OFF, 32'h1);
        rd("wrap_lo_post", IRQSRC_MTIME_LO_OFF, 32'h1);
        wr(IRQSRC_MTIME_LO_OFF, 32'h100);
        rd("sup_lo_load", IRQSRC_MTIME_LO_OFF, 32'h100);
        rd("sup_lo_next", IRQSRC_MTIME_LO_OFF, 32'h101);
        wr(IRQSRC_MTIME_HI_OFF, 32'h7);
        rd("sup_hi_lo_hold", IRQSRC_MTIME_LO_OFF, 32'h102);
        rd("sup_hi_val", IRQSRC_MTIME_HI_OFF, 32'h7);
        check_eq("mti_high", 64'(irq_o[CSR_MTIX_BIT]), 64'd1);
        wr(IRQSRC_MTIMECMP_HI_OFF, 32'hFFFF_FFFF);
        wr(IRQSRC_MTIMECMP_LO_OFF, 32'hFFFF_FFFF);
        check_eq("mti_low", 64'(irq_o[CSR_MTIX_BIT]), 64'd0);

        // MSIP: only bit 0 is stored.
        wr(IRQSRC_MSIP_OFF, 32'hFFFF_FFFF);
        check_eq("msi_set", 64'(irq_o[CSR_MSIX_BIT]), 64'd1);
        rd("msip_rd", IRQSRC_MSIP_OFF, 32'h1);
        wr(IRQSRC_MSIP_OFF, 32'h0);
        check_eq("msi_clr", 64'(irq_o[CSR_MSIX_BIT]), 64'd0);

        // Fast interrupts: edge capture and W1C.
        irq_fast_i = 16'h0004;
        idle();
        irq_fast_i = 16'h0000;
        check_eq("fast_edge", 64'(irq_o[31:16]), 64'h0004);
        idle();
        idle();
        check_eq("fast_sticky", 64'(irq_o[31:16]), 64'h0004);
        rd("fast_pend_rd", IRQSRC_FAST_PEND_OFF, 32'h4);
        irq_fast_i = 16'h0004;
        wr(IRQSRC_FAST_PEND_OFF, 32'h4);
        irq_fast_i = 16'h0000;
        check_eq("fast_set_wins", 64'(irq_o[31:16]), 64'h0004);
        idle();
        wr(IRQSRC_FAST_PEND_OFF, 32'h4);
        check_eq("fast_w1c", 64'(irq_o[31:16]), 64'h0000);
        irq_fast_i = 16'h8001;
        idle();
        irq_fast_i = 16'h0000;
        check_eq("fast_two", 64'(irq_o[31:16]), 64'h8001);
        wr(IRQSRC_FAST_PEND_OFF, 32'h0001);
        check_eq("fast_w1c_one", 64'(irq_o[31:16]), 64'h8000);
        irq_fast_i = 16'h0002;
        idle();
        check_eq("fast_held", 64'(irq_o[31:16]), 64'h8002);
        wr(IRQSRC_FAST_PEND_OFF, 32'h0002);
        check_eq("fast_held_w1c", 64'(irq_o[31:16]), 64'h8000);
        irq_fast_i = 16'h0000;

        // MEI through the two-flop synchroniser.
        meip_i = 1'b1;
        idle();
        check_eq("mei_rise_1", 64'(irq_o[CSR_MEIX_BIT]), 64'd0);
        idle();
        check_eq("mei_rise_2", 64'(irq_o[CSR_MEIX_BIT]), 64'd1);
        meip_i = 1'b0;
        idle();
        check_eq("mei_fall_1", 64'(irq_o[CSR_MEIX_BIT]), 64'd1);
        idle();
        check_eq("mei_fall_2", 64'(irq_o[CSR_MEIX_BIT]), 64'd0);

        // Asynchronous reset in the middle of a read response.
        meip_i = 1'b1;
        idle();
        idle();
        check_eq("pre_rst_irq", 64'(irq_o), 64'h8000_0800);
        bus_if.req_i  = 1'b1;
        bus_if.we_i   = 1'b0;
        bus_if.addr_i = IRQSRC_MTIMECMP_LO_OFF;
        @(posedge clk);
        #1;
        check_eq("pre_rst_rvalid", 64'(bus_if.rvalid_o), 64'd1);
        check_eq("pre_rst_rdata", 64'(bus_if.rdata_o), 64'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_rvalid", 64'(bus_if.rvalid_o), 64'd0);
        check_eq("async_rst_rdata", 64'(bus_if.rdata_o), 64'd0);
        check_eq("async_rst_irq", 64'(irq_o), 64'd0);
        bus_if.req_i  = 1'b0;
        bus_if.addr_i = '0;
        meip_i        = 1'b0;
        idle();
        rst_n = 1'b1;
        rd("post_rst_cmp_hi", IRQSRC_MTIMECMP_HI_OFF, 32'hFFFF_FFFF);
        rd("post_rst_pend", IRQSRC_FAST_PEND_OFF, 32'h0);
        rd("post_rst_prescale", IRQSRC_PRESCALE_OFF, 32'h0);
        check_eq("post_rst_irq", 64'(irq_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32imf_irq_source.md
# rv32imf_irq_source

Interrupt source block that generates the level-sensitive `irq_o[31:0]` vector consumed by the core's interrupt controller as its `irq_i`. It contains:
- a machine timer (64-bit `mtime` with prescaler, `mtimecmp`) driving MTI;
- a software-interrupt register driving MSI;
- a 2-flop synchroniser for the external machine interrupt driving MEI;
- 16 edge-captured, write-1-to-clear fast-interrupt pending bits.

All state is accessed over a simple single-cycle register bus.

## Interface
Parameters:
- `PRESCALE_W`, 16, width of prescaler register/counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  bus request.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  8  byte address. Bits [1:0] are ignored.
- `wdata_i`  in  32  write data. Full-word writes only.
- `gnt_o`  out  1  grant. Equal to `req_i` (combinational, always granted).
- `rvalid_o`  out  1  response valid, one cycle after an accepted request.
- `rdata_o`  out  32  read data. Valid with `rvalid_o`; 0 otherwise.
- `err_o`  out  1  unmapped address. Valid with `rvalid_o`.
- `meip_i`  in  1  external machine interrupt, asynchronous level.
- `irq_fast_i`  in  16  fast interrupt lines, synchronous to `clk`.
- `irq_o`  out  32  interrupt vector to the interrupt controller.

## Operation
Register map (word offsets):
- 0x00 MSIP: bit0 R/W. Upper bits read 0.
- 0x04 MTIMECMP_LO, R/W.
- 0x08 MTIMECMP_HI, R/W.
- 0x0C MTIME_LO, R/W.
- 0x10 MTIME_HI, R/W.
- 0x14 PRESCALE: [PRESCALE_W-1:0] R/W.
- 0x18 FAST_PEND: [15:0]. Read returns pending bits; write is W1C.
- Any other offset: read data 0, write ignored, `err_o`=1.

Prescaler and timer:
- `pcnt` counts 0..PRESCALE. `tick` = (`pcnt` == PRESCALE). On tick, `pcnt`←0 and `mtime`←`mtime`+1 (64-bit, wraps 2^64-1→0).
- PRESCALE=0 gives an increment every cycle.
- A write to PRESCALE resets `pcnt` to 0.
- A write to MTIME_LO or MTIME_HI loads that half. In the same cycle the increment is suppressed and `pcnt` holds.

MTI:
- `mti_q` ← (`mtime` >= `mtimecmp`), unsigned 64-bit compare, registered.

Fast interrupts:
- `fast_prev` ← `irq_fast_i` each cycle.
- `pend[i]` is set on a rising edge, i.e. `irq_fast_i[i]` & ~`fast_prev[i]`.
- A write of 1 to FAST_PEND bit i clears `pend[i]`.
- If a rising edge and a W1C hit the same bit in the same cycle, set wins.

MEI:
- `meip_i` passes through 2 flops to give `mei_s`.

Output mapping:
- `irq_o[3]` = MSIP.
- `irq_o[7]` = `mti_q`.
- `irq_o[11]` = `mei_s`.
- `irq_o[31:16]` = `pend`.
- All other bits 0.

## Timing
Reset values:
- `rvalid_o`, `rdata_o`, `err_o` = 0.
- `irq_o` = 0.
- MSIP=0, `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, PRESCALE=0, `pcnt`=0.
- `pend`=0, `fast_prev`=0, sync flops=0.

Bus:
- Request accepted in cycle N (`req_i`=1).
- Write takes effect at the clock edge ending cycle N.
- `rvalid_o`/`rdata_o`/`err_o` are asserted in cycle N+1 for one cycle.
- Back-to-back requests are supported, one per cycle.
- A read returns the register value sampled in cycle N, i.e. the pre-increment `mtime`.

Latencies:
- MTI: `irq_o[7]` reflects the compare result one cycle after `mtime`/`mtimecmp` change.
- MSIP write: visible on `irq_o[3]` in cycle N+1.
- Fast edge in cycle N: `irq_o[16+i]`=1 in cycle N+1.
- W1C in cycle N: bit cleared in cycle N+1.
- MEI: 2-cycle synchroniser latency.

Reset asserted mid-operation:
- All state returns to reset values immediately (asynchronous).
- An in-flight response is dropped, with `rvalid_o`=0.

## Structure
- Register offsets (`IRQSRC_MSIP_OFF` … `IRQSRC_FAST_PEND_OFF`) and the `mtimecmp` reset constant go in `rv32imf_pkg`.
- Output bit positions use the existing package constants `CSR_MSIX_BIT`, `CSR_MTIX_BIT`, `CSR_MEIX_BIT`.
- One sub-module, `rv32imf_irq_source_timer`, holds `pcnt`, `mtime`, `mtimecmp` and the compare flop, with load strobes and an `mti` output.
- Bus decode, MSIP, the fast-interrupt logic and the synchroniser stay in the top.

## Test plan
- Reset, then read all offsets → MTIMECMP reads 0xFFFFFFFF, all other registers 0, `irq_o`=0, `err_o`=0. Read 0x40 → `rdata_o`=0, `err_o`=1.
- PRESCALE=3, MTIMECMP_HI=0, MTIMECMP_LO=5 → `mtime` increments every 4 cycles, and `irq_o[7]` rises 1 cycle after `mtime` reaches 5.
- MTIME_LO=0xFFFFFFFF, MTIME_HI=0 with PRESCALE=0 → after one tick MTIME_HI=1 and MTIME_LO=0. A write coinciding with a tick suppresses that increment.
- Write MSIP=1 → `irq_o[3]`=1 the next cycle. Write MSIP=0 → `irq_o[3]` clears.
- Pulse `irq_fast_i[2]` for 1 cycle → `irq_o[18]` stays 1. W1C 0x4 in the same cycle as a new edge → bit stays 1. A later W1C alone → bit clears.
- Toggle `meip_i` → `irq_o[11]` follows after 2 cycles. Assert `rst_n` low mid-read → `rvalid_o`=0 and `irq_o`=0 immediately.
